explosao_animada: RTL and testbench

Parametrised explosion animation generator for the bomb-timer display path. When the countdown reports expiry on `TEMPO_ACABOU`, the block plays a frame-rate-controlled animation on N seven-segment displays and M red LEDs. It supports three selectable patterns and a finite or endless loop count, and ends in a full-on "detonated" frame. Its outputs feed the same HEX/LEDR output multiplexer that the countdown display uses.

---
 rtl/explosao_animada_if.sv | 38 +++
 rtl/explosao_animada.sv | 216 +++++++++++++++++++++
 tb/tb_explosao_animada.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/explosao_animada_if.sv
// explosao_animada_if: bundles the request and display-output signals of the
// explosion animation block.
//   TEMPO_ACABOU  : countdown expired (level); starts, sustains or aborts the animation
//   MODO          : pattern select (latched by the animation block at start)
//   EXPLOSAO_HEX  : N_HEX seven-segment digits, 7 bits each, active-low segments
//   EXPLOSAO_LEDR : N_LEDR red LEDs, active-high
//   ATIVO         : animation running
//   CONCLUIDO     : final "detonated" frame being held
// master = the side that requests the animation, slave = the animation block.
interface explosao_animada_if #(
   parameter int N_HEX  = 8,
   parameter int N_LEDR = 18
);
   logic                 TEMPO_ACABOU;
   logic [1:0]           MODO;
   logic [7*N_HEX-1:0]   EXPLOSAO_HEX;
   logic [N_LEDR-1:0]    EXPLOSAO_LEDR;
   logic                 ATIVO;
   logic                 CONCLUIDO;

   modport master (
      output TEMPO_ACABOU,
      output MODO,
      input  EXPLOSAO_HEX,
      input  EXPLOSAO_LEDR,
      input  ATIVO,
      input  CONCLUIDO
   );

   modport slave (
      input  TEMPO_ACABOU,
      input  MODO,
      output EXPLOSAO_HEX,
      output EXPLOSAO_LEDR,
      output ATIVO,
      output CONCLUIDO
   );
endinterface

// File: rtl/explosao_animada.sv
// explosao_animada: explosion animation generator for the bomb-timer display.
// When bus.TEMPO_ACABOU rises the block plays one of three frame patterns
// (varredura / pisca / perseguicao) at one frame every DIV_CICLOS clocks,
// repeats it N_CICLOS times (0 = forever) and then holds a full-on frame.
// Ports:
//   CLOCK : system clock
//   RESET : synchronous, active-high; overrides everything else
//   bus   : explosao_animada_if slave (TEMPO_ACABOU, MODO in;
//           EXPLOSAO_HEX, EXPLOSAO_LEDR, ATIVO, CONCLUIDO out, all registered)
module explosao_animada #(
   parameter int N_HEX      = 8,
   parameter int N_LEDR     = 18,
   parameter int DIV_CICLOS = 12500000,
   parameter int N_CICLOS   = 3
) (
   input  logic               CLOCK,
   input  logic               RESET,
   explosao_animada_if.slave  bus
);

   localparam int DIV_W   = (DIV_CICLOS > 1) ? $clog2(DIV_CICLOS) : 1;
   localparam int FRAME_W = $clog2((N_HEX > 4) ? N_HEX : 4);
   localparam int LOOP_W0 = $clog2(N_CICLOS + 1);
   // With N_CICLOS = 0 the loop counter is never advanced; one bit keeps it legal.
   localparam int LOOP_W  = (LOOP_W0 > 0) ? LOOP_W0 : 1;

   localparam logic [DIV_W-1:0]   DIV_ULT    = DIV_W'(DIV_CICLOS - 1);
   localparam logic [LOOP_W-1:0]  LOOP_ALVO  = LOOP_W'(N_CICLOS);
   localparam logic [7*N_HEX-1:0] HEX_BRANCO = {N_HEX{7'h7F}};
   localparam logic [7*N_HEX-1:0] HEX_FINAL  = {(7*N_HEX){1'b0}};
   localparam logic [N_LEDR-1:0]  LEDR_BRAN  = {N_LEDR{1'b0}};
   localparam logic [N_LEDR-1:0]  LEDR_FINAL = {N_LEDR{1'b1}};

   typedef enum logic [1:0] {
      OCIOSO   = 2'd0,
      ANIMANDO = 2'd1,
      FIM      = 2'd2
   } estado_t;

   estado_t              estado_r;
   logic [1:0]           modo_r;
   logic [DIV_W-1:0]     div_r;
   logic [FRAME_W-1:0]   quadro_r;
   logic [LOOP_W-1:0]    laco_r;
   logic [7*N_HEX-1:0]   hex_r;
   logic [N_LEDR-1:0]    ledr_r;
   logic                 ativo_r;
   logic                 concluido_r;

   logic [FRAME_W-1:0]   quadro_ult_s;
   logic [FRAME_W-1:0]   quadro_prox_s;
   logic [LOOP_W-1:0]    laco_prox_s;
   logic                 div_fim_s;
   logic                 quadro_fim_s;
   logic                 fim_laco_s;

   // Seven-segment image of frame f for pattern modo (MODO 3 falls into varredura).
   function automatic logic [7*N_HEX-1:0] hex_quadro(input logic [1:0] modo,
                                                     input logic [FRAME_W-1:0] f);
      logic [7*N_HEX-1:0] r;
      logic [6:0]         seg;
      r   = HEX_BRANCO;
      seg = 7'h7F;
      case (modo)
         2'd1: begin
            if (f == FRAME_W'(0)) r = HEX_FINAL;
            else                  r = HEX_BRANCO;
         end
         2'd2: begin
            for (int k = 0; k < N_HEX; k++) begin
               if (f == FRAME_W'(k)) r[7*k +: 7] = 7'h00;
               else                  r[7*k +: 7] = 7'h7F;
            end
         end
         default: begin
            case (f[1:0])
               2'd0:    seg = 7'b1111100;
               2'd1:    seg = 7'b1110011;
               2'd2:    seg = 7'b1001111;
               default: seg = 7'b0111111;
            endcase
            r = {N_HEX{seg}};
         end
      endcase
      return r;
   endfunction

   // LED image of frame f for pattern modo.
   function automatic logic [N_LEDR-1:0] ledr_quadro(input logic [1:0] modo,
                                                     input logic [FRAME_W-1:0] f);
      logic [N_LEDR-1:0] r;
      r = LEDR_BRAN;
      case (modo)
         2'd1: begin
            if (f == FRAME_W'(0)) r = LEDR_FINAL;
            else                  r = LEDR_BRAN;
         end
         2'd2: begin
            for (int i = 0; i < N_LEDR; i++) r[i] = (FRAME_W'(i % N_HEX) == f);
         end
         default: begin
            for (int i = 0; i < N_LEDR; i++) r[i] = (2'(i % 4) == f[1:0]);
         end
      endcase
      return r;
   endfunction

   // Frame/loop bookkeeping for the current pattern.
   always_comb begin
      quadro_ult_s = FRAME_W'(3);
      case (modo_r)
         2'd1:    quadro_ult_s = FRAME_W'(1);
         2'd2:    quadro_ult_s = FRAME_W'(N_HEX - 1);
         default: quadro_ult_s = FRAME_W'(3);
      endcase
      div_fim_s    = (div_r == DIV_ULT);
      quadro_fim_s = (quadro_r == quadro_ult_s);
      laco_prox_s  = laco_r + LOOP_W'(1);
      if (quadro_fim_s) begin
         quadro_prox_s = {FRAME_W{1'b0}};
      end else begin
         quadro_prox_s = quadro_r + FRAME_W'(1);
      end
      fim_laco_s = quadro_fim_s && (N_CICLOS != 0) && (laco_prox_s == LOOP_ALVO);
   end

   // Animation state machine with registered display outputs.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         estado_r    <= OCIOSO;
         modo_r      <= 2'd0;
         div_r       <= {DIV_W{1'b0}};
         quadro_r    <= {FRAME_W{1'b0}};
         laco_r      <= {LOOP_W{1'b0}};
         hex_r       <= HEX_BRANCO;
         ledr_r      <= LEDR_BRAN;
         ativo_r     <= 1'b0;
         concluido_r <= 1'b0;
      end else begin
         case (estado_r)
            OCIOSO: begin
               div_r    <= {DIV_W{1'b0}};
               quadro_r <= {FRAME_W{1'b0}};
               laco_r   <= {LOOP_W{1'b0}};
               if (bus.TEMPO_ACABOU) begin
                  estado_r    <= ANIMANDO;
                  modo_r      <= bus.MODO;
                  hex_r       <= hex_quadro(bus.MODO, {FRAME_W{1'b0}});
                  ledr_r      <= ledr_quadro(bus.MODO, {FRAME_W{1'b0}});
                  ativo_r     <= 1'b1;
                  concluido_r <= 1'b0;
               end else begin
                  hex_r       <= HEX_BRANCO;
                  ledr_r      <= LEDR_BRAN;
                  ativo_r     <= 1'b0;
                  concluido_r <= 1'b0;
               end
            end
            ANIMANDO: begin
               // An abort wins over a frame advance on the same edge.
               if (!bus.TEMPO_ACABOU) begin
                  estado_r    <= OCIOSO;
                  hex_r       <= HEX_BRANCO;
                  ledr_r      <= LEDR_BRAN;
                  ativo_r     <= 1'b0;
                  concluido_r <= 1'b0;
               end else if (div_fim_s) begin
                  div_r <= {DIV_W{1'b0}};
                  if (fim_laco_s) begin
                     estado_r    <= FIM;
                     hex_r       <= HEX_FINAL;
                     ledr_r      <= LEDR_FINAL;
                     ativo_r     <= 1'b0;
                     concluido_r <= 1'b1;
                  end else begin
                     quadro_r <= quadro_prox_s;
                     hex_r    <= hex_quadro(modo_r, quadro_prox_s);
                     ledr_r   <= ledr_quadro(modo_r, quadro_prox_s);
                     if (quadro_fim_s && (N_CICLOS != 0)) begin
                        laco_r <= laco_prox_s;
                     end else begin
                        laco_r <= laco_r;
                     end
                  end
               end else begin
                  div_r <= div_r + DIV_W'(1);
               end
            end
            FIM: begin
               if (!bus.TEMPO_ACABOU) begin
                  estado_r    <= OCIOSO;
                  hex_r       <= HEX_BRANCO;
                  ledr_r      <= LEDR_BRAN;
                  ativo_r     <= 1'b0;
                  concluido_r <= 1'b0;
               end else begin
                  estado_r <= FIM;
               end
            end
            default: begin
               estado_r    <= OCIOSO;
               hex_r       <= HEX_BRANCO;
               ledr_r      <= LEDR_BRAN;
               ativo_r     <= 1'b0;
               concluido_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.EXPLOSAO_HEX  = hex_r;
   assign bus.EXPLOSAO_LEDR = ledr_r;
   assign bus.ATIVO         = ativo_r;
   assign bus.CONCLUIDO     = concluido_r;

endmodule

// File: tb/tb_explosao_animada.sv
// Testbench for explosao_animada: directed scenarios plus random stimulus,
// checked against a time-based reference model through a scoreboard queue.
module tb_explosao_animada;
   localparam int NH  = 8;
   localparam int NL  = 18;
   localparam int DIV = 2;
   localparam int NC  = 2;

   typedef struct packed {
      logic [7*NH-1:0] hex;
      logic [NL-1:0]   ledr;
      logic            ativo;
      logic            conc;
   } saida_t;

   logic clock;
   logic rst;
   int   n_total;
   int   n_ok;
   saida_t fila[$];
   saida_t esperado;

   // reference model state: running flag, cycles since start edge, latched mode
   bit m_on;
   int m_t;
   int m_modo;
   logic [6:0] vseg [4] = '{7'b1111100, 7'b1110011, 7'b1001111, 7'b0111111};

   explosao_animada_if #(.N_HEX(NH), .N_LEDR(NL)) bus ();

   explosao_animada #(.N_HEX(NH), .N_LEDR(NL), .DIV_CICLOS(DIV), .N_CICLOS(NC)) dut (
      .CLOCK (clock),
      .RESET (rst),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Expected outputs from elapsed time since the start edge.
   function automatic saida_t modelo(bit on, int t, int modo);
      saida_t s;
      int nf, f;
      s.hex = {NH{7'h7F}};
      s.ledr = '0;
      s.ativo = 1'b0;
      s.conc = 1'b0;
      if (on) begin
         nf = (modo == 1) ? 2 : ((modo == 2) ? NH : 4);
         if (NC != 0 && t >= NC * nf * DIV) begin
            s.hex = '0;
            s.ledr = '1;
            s.conc = 1'b1;
         end else begin
            s.ativo = 1'b1;
            f = (t / DIV) % nf;
            for (int k = 0; k < NH; k++) begin
               if (modo == 1)      s.hex[7*k +: 7] = (f == 0) ? 7'h00 : 7'h7F;
               else if (modo == 2) s.hex[7*k +: 7] = (k == f) ? 7'h00 : 7'h7F;
               else                s.hex[7*k +: 7] = vseg[f];
            end
            for (int i = 0; i < NL; i++) begin
               if (modo == 1)      s.ledr[i] = (f == 0);
               else if (modo == 2) s.ledr[i] = ((i % NH) == f);
               else                s.ledr[i] = ((i % 4) == f);
            end
         end
      end
      return s;
   endfunction

   // One clock: drive inputs, advance the model, queue the expected result.
   task automatic step(input bit r, input bit ta, input logic [1:0] md);
      @(negedge clock);
      rst = r;
      bus.TEMPO_ACABOU = ta;
      bus.MODO = md;
      if (r || !ta) begin
         m_on = 1'b0;
      end else if (!m_on) begin
         m_on = 1'b1;
         m_t = 0;
         m_modo = (md == 2'd3) ? 0 : int'(md);
      end else begin
         m_t = m_t + 1;
      end
      fila.push_back(modelo(m_on, m_t, m_modo));
      @(posedge clock);
      #2;
   endtask

   task automatic steps(input int n, input bit ta, input logic [1:0] md);
      for (int i = 0; i < n; i++) step(1'b0, ta, md);
   endtask

   task automatic chk(input string nome, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got === exp) n_ok++;
      else $display("FAIL %s got=%h exp=%h", nome, got, exp);
   endtask

   // Scoreboard monitor: one output word per clock edge.
   always @(posedge clock) begin
      #1;
      if (fila.size() > 0) begin
         esperado = fila.pop_front();
         n_total++;
         if ({bus.EXPLOSAO_HEX, bus.EXPLOSAO_LEDR, bus.ATIVO, bus.CONCLUIDO} === esperado) begin
            n_ok++;
         end else begin
            $display("FAIL saida t=%0t got hex=%h ledr=%h at=%b cc=%b exp hex=%h ledr=%h at=%b cc=%b",
                     $time, bus.EXPLOSAO_HEX, bus.EXPLOSAO_LEDR, bus.ATIVO, bus.CONCLUIDO,
                     esperado.hex, esperado.ledr, esperado.ativo, esperado.conc);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      n_total = 0;
      n_ok = 0;
      m_on = 1'b0;
      m_t = 0;
      m_modo = 0;
      rst = 1'b1;
      bus.TEMPO_ACABOU = 1'b1;
      bus.MODO = 2'd0;

      // reset dominates a high TEMPO_ACABOU
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 2'd0);
      chk("reset_hex", 64'(bus.EXPLOSAO_HEX), 64'({NH{7'h7F}}));
      chk("reset_ledr", 64'(bus.EXPLOSAO_LEDR), 64'h0);
      chk("reset_flags", {62'h0, bus.ATIVO, bus.CONCLUIDO}, 64'h0);

      // varredura to completion
      step(1'b0, 1'b1, 2'd0);
      chk("varr_f0_hex", 64'(bus.EXPLOSAO_HEX[6:0]), 64'(7'b1111100));
      chk("varr_f0_ledr", 64'(bus.EXPLOSAO_LEDR), 64'h11111);
      steps(15, 1'b1, 2'd0);
      chk("varr_pre_fim", {62'h0, bus.ATIVO, bus.CONCLUIDO}, 64'h2);
      step(1'b0, 1'b1, 2'd0);
      chk("varr_fim_ledr", 64'(bus.EXPLOSAO_LEDR), 64'h3FFFF);
      chk("varr_fim_flags", {62'h0, bus.ATIVO, bus.CONCLUIDO}, 64'h1);
      steps(10, 1'b1, 2'd3);
      chk("varr_hold_hex", 64'(bus.EXPLOSAO_HEX), 64'h0);
      step(1'b0, 1'b0, 2'd0);
      chk("varr_drop_hex", 64'(bus.EXPLOSAO_HEX), 64'({NH{7'h7F}}));

      // abort during frame 2, then restart
      step(1'b0, 1'b1, 2'd3);
      steps(4, 1'b1, 2'd1);
      chk("abort_pre_f2", 64'(bus.EXPLOSAO_HEX[6:0]), 64'(7'b1001111));
      step(1'b0, 1'b0, 2'd0);
      chk("abort_blank", {bus.EXPLOSAO_LEDR, bus.ATIVO}, 64'h0);
      step(1'b0, 1'b1, 2'd0);
      chk("restart_f0", 64'(bus.EXPLOSAO_HEX[6:0]), 64'(7'b1111100));
      step(1'b0, 1'b0, 2'd0);

      // perseguicao
      step(1'b0, 1'b1, 2'd2);
      chk("pers_f0_hex", 64'(bus.EXPLOSAO_HEX), 64'({{7{7'h7F}}, 7'h00}));
      chk("pers_f0_ledr", 64'(bus.EXPLOSAO_LEDR), 64'h10101);
      steps(6, 1'b1, 2'd2);
      chk("pers_f3_ledr", 64'(bus.EXPLOSAO_LEDR), 64'h00808);
      chk("pers_f3_hex3", 64'(bus.EXPLOSAO_HEX[27:21]), 64'h0);
      steps(25, 1'b1, 2'd2);
      chk("pers_pre_fim", 64'(bus.CONCLUIDO), 64'h0);
      step(1'b0, 1'b1, 2'd2);
      chk("pers_fim", 64'(bus.CONCLUIDO), 64'h1);
      step(1'b0, 1'b0, 2'd2);

      // pisca with a mid-run MODO change, then reset in frame 1
      step(1'b0, 1'b1, 2'd1);
      chk("pisca_f0_hex", 64'(bus.EXPLOSAO_HEX), 64'h0);
      steps(2, 1'b1, 2'd0);
      chk("pisca_f1_hex", 64'(bus.EXPLOSAO_HEX), 64'({NH{7'h7F}}));
      chk("pisca_f1_ativo", 64'(bus.ATIVO), 64'h1);
      step(1'b1, 1'b1, 2'd0);
      chk("pisca_reset", {bus.EXPLOSAO_LEDR, bus.ATIVO, bus.CONCLUIDO}, 64'h0);
      step(1'b0, 1'b0, 2'd0);

      // randomized stimulus
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 59) == 0), ($urandom_range(0, 39) != 0),
              2'($urandom_range(0, 3)));
      end

      for (int i = 0; i < 10 && fila.size() > 0; i++) @(negedge clock);
      n_total++;
      if (fila.size() == 0) n_ok++;
      else $display("FAIL drain pending=%0d exp=0", fila.size());

      $display("%0d/%0d checks passed", n_ok, n_total);
      $finish;
   end
endmodule
